// File: rtl/rmii_rx_if.sv
// RMII receive pins plus the FWFT receive-buffer read port, grouped for rmii_rx.
interface rmii_rx_if;
  logic [1:0] p_rxd;
  logic       p_crs_dv;
  logic       rx_rd;
  logic       rx_av;
  logic [7:0] rx_data;
  logic       rx_last;
  logic       rx_err;
  logic       rx_ovf;
  logic       rx_bz;

  modport master (output p_rxd, p_crs_dv, rx_rd,
                  input  rx_av, rx_data, rx_last, rx_err, rx_ovf, rx_bz);
  modport slave  (input  p_rxd, p_crs_dv, rx_rd,
                  output rx_av, rx_data, rx_last, rx_err, rx_ovf, rx_bz);
endinterface

// File: rtl/rmii_rx.sv
// RMII receiver: preamble/SFD strip, LSB-first byte assembly, circular buffer
// of {err,last,data} entries drained through a first-word-fall-through port.
module rmii_rx #(
  parameter int ADDR_W  = 11,
  parameter int MIN_PRE = 8
) (
  input logic      clk,
  input logic      rst,
  rmii_rx_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {DROP, IDLE, PRE, PAY} state_t;

  state_t            state;
  logic [5:0]        pre_cnt;
  logic [1:0]        dibit_cnt;
  logic [7:0]        shift, stg;
  logic              stg_vld, pending, ovf_q;

  logic [9:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr;
  logic [ADDR_W:0]   count;
  logic [9:0]        head, push_din;
  logic [7:0]        byte_done;
  logic              full, pop, push_req, push_ok, is_term, ovf;

  assign byte_done = {bus.p_rxd, shift[7:2]};
  assign full      = count[ADDR_W];
  assign pop       = bus.rx_rd && (count != '0);
  assign push_ok   = push_req && (!full || pop);
  assign ovf       = push_req && !push_ok && !is_term;

  // Pending terminator only exists outside PAY with staging empty, so one push source per cycle.
  always_comb begin
    push_req = 1'b0;
    is_term  = 1'b0;
    push_din = '0;
    if (pending) begin
      push_req = 1'b1;
      is_term  = 1'b1;
      push_din = 10'h300;
    end else if (state == PAY && stg_vld) begin
      if (bus.p_crs_dv) begin
        if (dibit_cnt == 2'd3) begin
          push_req = 1'b1;
          push_din = {2'b00, stg};
        end
      end else begin
        push_req = 1'b1;
        push_din = {dibit_cnt != 2'd0, 1'b1, stg};
      end
    end
  end

  always_ff @(posedge clk)
    if (push_ok) mem[wptr] <= push_din;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + ADDR_W'(1);
      if (pop)     rptr <= rptr + ADDR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= DROP;
      pre_cnt   <= '0;
      dibit_cnt <= '0;
      shift     <= '0;
      stg       <= '0;
      stg_vld   <= 1'b0;
      pending   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ovf_q <= ovf;
      case (state)
        DROP: if (!bus.p_crs_dv) state <= IDLE;
        IDLE: if (bus.p_crs_dv) begin
          if (bus.p_rxd == 2'b01 && !pending) begin
            state   <= PRE;
            pre_cnt <= 6'd1;
          end else if (bus.p_rxd != 2'b00) begin
            state <= DROP;
          end
        end
        PRE: begin
          if (!bus.p_crs_dv) state <= IDLE;
          else if (bus.p_rxd == 2'b01) begin
            if (pre_cnt != 6'd63) pre_cnt <= pre_cnt + 6'd1;
          end else if (bus.p_rxd == 2'b11 && pre_cnt >= 6'(MIN_PRE)) begin
            state     <= PAY;
            dibit_cnt <= '0;
          end else state <= DROP;
        end
        PAY: begin
          if (bus.p_crs_dv) begin
            shift     <= byte_done;
            dibit_cnt <= dibit_cnt + 2'd1;
            if (dibit_cnt == 2'd3) begin
              stg     <= byte_done;
              stg_vld <= 1'b1;
            end
          end else begin
            state   <= IDLE;
            stg_vld <= 1'b0;
          end
        end
        default: state <= DROP;
      endcase
      // A discarded byte aborts the frame; the terminator marks the cut in the stream.
      if (ovf) begin
        state   <= DROP;
        stg_vld <= 1'b0;
        pending <= 1'b1;
      end else if (push_ok && is_term) begin
        pending <= 1'b0;
      end
    end
  end

  assign head        = mem[rptr];
  assign bus.rx_av   = (count != '0);
  assign bus.rx_data = bus.rx_av ? head[7:0] : 8'h00;
  assign bus.rx_last = bus.rx_av & head[8];
  assign bus.rx_err  = bus.rx_av & head[9];
  assign bus.rx_ovf  = ovf_q;
  assign bus.rx_bz   = (state == PRE) || (state == PAY);
endmodule

// File: doc/rmii_rx.md
Name: rmii_rx

Overview:
RMII receive path, the receive-side counterpart of the RMII transmitter. It samples RXD[1:0] and CRS_DV on the 50 MHz RMII reference clock and strips the preamble and SFD. It assembles payload bytes LSB-dibit-first and places them in a circular receive buffer. The MAC/packet logic drains the buffer through a first-word-fall-through read port that carries per-byte end-of-frame and error tags.

Parameters:
ADDR_W, 11, buffer address width; depth = 2**ADDR_W entries (2048)
MIN_PRE, 8, minimum count of 01 dibits before the 11 SFD dibit for a frame to be accepted

Ports:
clk  input  1  RMII 50 MHz reference clock; all logic on posedge
rst  input  1  asynchronous active-low reset
p_rxd  input  2  RMII receive dibit
p_crs_dv  input  1  RMII carrier sense / data valid, used as a plain data-valid; no CRS toggle decoding
rx_rd  input  1  pop the head entry; ignored when rx_av=0
rx_av  output  1  buffer not empty
rx_data  output  8  head entry data byte
rx_last  output  1  head entry is the last entry of its frame
rx_err  output  1  head entry belongs to a frame that ended in error
rx_ovf  output  1  one-cycle pulse when a byte is discarded because the buffer is full
rx_bz  output  1  high while state is PRE or PAY

Behaviour:
- Reset: state=DROP, pointers=0, count=0, staging empty, pending-terminator clear. rx_av, rx_data, rx_last, rx_err, rx_ovf and rx_bz are all 0.
- Buffer entries are 10 bits: {err, last, data}. Count is ADDR_W+1 bits wide, and pointers wrap modulo depth.
- Read port is FWFT: the head entry is visible while rx_av=1, and rx_rd advances the head on the next edge.
- Write latency: a pushed entry makes rx_av visible on the following cycle.
- A push is accepted when count<depth, or when the buffer is full and an accepted pop occurs in the same cycle.
- DROP state: waits for p_crs_dv=0, then goes to IDLE. Nothing is written while in DROP.
- IDLE state:
  - p_crs_dv=1 and p_rxd=01: go to PRE with pre_cnt=1.
  - p_crs_dv=1 and p_rxd=00: stay in IDLE.
  - Any other dibit with p_crs_dv=1: go to DROP.
- PRE state:
  - p_rxd=01: pre_cnt increments, saturating at 63.
  - p_rxd=11 with pre_cnt>=MIN_PRE: go to PAY, dibit_cnt=0.
  - p_rxd=11 with pre_cnt<MIN_PRE: go to DROP.
  - p_rxd=00 or 10: go to DROP.
  - p_crs_dv=0: go to IDLE.
- PAY state, per cycle with p_crs_dv=1:
  - shift = {p_rxd, shift[7:2]}; dibit_cnt increments modulo 4.
  - When dibit_cnt==3, the completed byte enters the staging register. Any previously staged byte is pushed first with last=0, err=0.
- PAY end (p_crs_dv=0):
  - dibit_cnt==0 and staging full: push the staged byte with last=1, err=0.
  - dibit_cnt!=0 and staging full: push the staged byte with last=1, err=1. The partial byte is discarded.
  - Staging empty (runt after SFD): no entry is written.
  - In every case, go to IDLE and clear staging.
- Overflow: a push attempted while the buffer is full is discarded and rx_ovf pulses for one cycle.
  - State goes to DROP, staging is cleared, and pending-terminator is set.
  - While pending-terminator is set, the terminator entry {err=1, last=1, data=0x00} is pushed on the first cycle a push is accepted, and pending-terminator then clears.
  - No new frame is accepted out of DROP/IDLE until the terminator has been written.
- Simultaneous events:
  - Terminator push and staged push never coincide, because staging is empty while pending.
  - Push and pop in the same cycle leave count unchanged.
- Reset mid-frame: everything clears, and the receiver re-enters through DROP. The remainder of the current frame is therefore never misparsed as a preamble.

Test Plan:
- 31×01, then 11, then bytes 0x55, 0xAA, 0x12 (dibit LSB first), then p_crs_dv=0 -> entries 55/0/0, AA/0/0, 12/last=1/err=0; rx_bz high from the first 01 until one cycle after p_crs_dv falls.
- Valid preamble + SFD, bytes 0x01, 0x02, then 2 extra dibits, then p_crs_dv=0 -> entries 01/0/0, 02/last=1/err=1.
- Preamble 01, 01, 10 -> DROP, no entries, rx_bz=0. The next valid frame with byte 0x7E yields a single entry 7E/last=1.
- MIN_PRE=8 with 5×01 then 11 and 4 bytes -> no entries. The same frame with 8×01 -> 4 entries.
- ADDR_W=4, no reads, 20-byte frame:
  - 16 entries are written.
  - rx_ovf pulses once, on the 17th push attempt.
  - One rx_rd after the frame causes entry {err=1, last=1, 0x00} to be written at the tail.
- Reset asserted mid-payload, released while p_crs_dv=1 with p_rxd=01 -> no entries until p_crs_dv goes low. A following frame is received normally.
